// File: rtl/trivius_pkg.sv
// Shared MIDI constants, parser state encoding and the note event payload
// used by the voice allocator.
package trivius_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  // 0xF8..0xFF real-time, 0xF0..0xF7 system-common/exclusive
  localparam logic [7:0] MIDI_RT_LO    = 8'hF8;
  localparam logic [7:0] MIDI_SYS_LO   = 8'hF0;

  typedef logic [6:0] note_t;
  typedef logic [6:0] vel_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IGNORE  = 2'd1,
    ST_WAIT_D1 = 2'd2,
    ST_WAIT_D2 = 2'd3
  } parser_state_t;

  typedef struct packed {
    logic  on;
    note_t note;
    vel_t  velocity;
  } midi_event_t;

endpackage

// File: rtl/midi_parser.sv
// Byte-level MIDI parser: keeps running status for Note On/Off on one
// channel and emits a one-cycle registered event per completed data pair.
module midi_parser
  import trivius_pkg::*;
#(
  parameter int unsigned MIDI_CHANNEL = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output midi_event_t o_event,
  output logic        o_event_valid
);

  localparam logic [3:0] CHAN = 4'(MIDI_CHANNEL);

  parser_state_t state_q, state_d;
  logic          cmd_on_q, cmd_on_d;
  note_t         note_q, note_d;
  midi_event_t   ev_q, ev_d;
  logic          ev_valid_q, ev_valid_d;

  // State, latched command/note and event output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cmd_on_q   <= 1'b0;
      note_q     <= '0;
      ev_q       <= '0;
      ev_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_on_q   <= cmd_on_d;
      note_q     <= note_d;
      ev_q       <= ev_d;
      ev_valid_q <= ev_valid_d;
    end
  end

  // Next-state decode; real-time bytes fall through untouched
  always_comb begin
    state_d    = state_q;
    cmd_on_d   = cmd_on_q;
    note_d     = note_q;
    ev_d       = ev_q;
    ev_valid_d = 1'b0;
    if (i_valid && (i_data < MIDI_RT_LO)) begin
      if (i_data >= MIDI_SYS_LO) begin
        state_d = ST_IDLE;
      end else if (i_data[7]) begin
        if (((i_data[7:4] == MIDI_NOTE_ON) || (i_data[7:4] == MIDI_NOTE_OFF)) &&
            (i_data[3:0] == CHAN)) begin
          cmd_on_d = (i_data[7:4] == MIDI_NOTE_ON);
          state_d  = ST_WAIT_D1;
        end else begin
          state_d  = ST_IGNORE;
        end
      end else begin
        case (state_q)
          ST_WAIT_D1: begin
            note_d  = i_data[6:0];
            state_d = ST_WAIT_D2;
          end
          ST_WAIT_D2: begin
            // Note On with zero velocity is a Note Off
            ev_valid_d  = 1'b1;
            ev_d.on       = cmd_on_q && (i_data[6:0] != 7'd0);
            ev_d.note     = note_q;
            ev_d.velocity = i_data[6:0];
            state_d       = ST_WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_event       = ev_q;
  assign o_event_valid = ev_valid_q;

endmodule

// File: rtl/voice_alloc.sv
// MIDI Note On/Off scheduler onto a fixed voice pool with age ranking.
// Optional feature macro VOICE_STEAL_EN: when every voice is busy the
// oldest voice is overwritten instead of discarding the Note On.
module voice_alloc
  import trivius_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 4,
  parameter int unsigned MIDI_CHANNEL = 0
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic [7:0]                  i_data,
  output logic [NUM_VOICES-1:0]       o_gate,
  output logic [NUM_VOICES-1:0][6:0]  o_note,
  output logic [NUM_VOICES-1:0][6:0]  o_velocity,
  output logic [NUM_VOICES-1:0]       o_update,
  output logic                        o_dropped
);

  localparam int unsigned RANK_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  midi_event_t pev;
  logic        pev_valid;
  midi_event_t ev_q;
  logic        ev_valid_q;

  logic [NUM_VOICES-1:0]      gate_q, gate_d;
  logic [NUM_VOICES-1:0][6:0] note_q, note_d;
  logic [NUM_VOICES-1:0][6:0] vel_q, vel_d;
  logic [NUM_VOICES-1:0]      upd_q, upd_d;
  logic                       drop_q, drop_d;
  logic [RANK_W-1:0]          rank_q [NUM_VOICES];
  logic [RANK_W-1:0]          rank_d [NUM_VOICES];
  logic                       sel_found;
  logic [RANK_W-1:0]          sel;

  midi_parser #(.MIDI_CHANNEL(MIDI_CHANNEL)) u_parser (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .o_event       (pev),
    .o_event_valid (pev_valid)
  );

  // Event stage plus voice state; ranks reset to identity permutation
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ev_q       <= '0;
      ev_valid_q <= 1'b0;
      gate_q     <= '0;
      note_q     <= '0;
      vel_q      <= '0;
      upd_q      <= '0;
      drop_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_VOICES); i++) rank_q[i] <= RANK_W'(i);
    end else begin
      ev_q       <= pev;
      ev_valid_q <= pev_valid;
      gate_q     <= gate_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      upd_q      <= upd_d;
      drop_q     <= drop_d;
      for (int i = 0; i < int'(NUM_VOICES); i++) rank_q[i] <= rank_d[i];
    end
  end

  // Allocation: retrigger, else lowest free voice, else steal or drop
  always_comb begin
    gate_d    = gate_q;
    note_d    = note_q;
    vel_d     = vel_q;
    upd_d     = '0;
    drop_d    = 1'b0;
    rank_d    = rank_q;
    sel_found = 1'b0;
    sel       = '0;
    if (ev_valid_q) begin
      if (ev_q.on) begin
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
          if (!sel_found && gate_q[i] && (note_q[i] == ev_q.note)) begin
            sel_found = 1'b1;
            sel       = RANK_W'(i);
          end
        end
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
          if (!sel_found && !gate_q[i]) begin
            sel_found = 1'b1;
            sel       = RANK_W'(i);
          end
        end
`ifdef VOICE_STEAL_EN
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
          if (!sel_found && (rank_q[i] == RANK_W'(NUM_VOICES - 1))) begin
            sel_found = 1'b1;
            sel       = RANK_W'(i);
          end
        end
`endif
        if (sel_found) begin
          gate_d[sel] = 1'b1;
          note_d[sel] = ev_q.note;
          vel_d[sel]  = ev_q.velocity;
          upd_d[sel]  = 1'b1;
          // Younger voices age by one; the chosen voice becomes newest
          for (int j = 0; j < int'(NUM_VOICES); j++) begin
            if (rank_q[j] < rank_q[sel]) rank_d[j] = rank_q[j] + RANK_W'(1);
          end
          rank_d[sel] = '0;
        end else begin
          drop_d = 1'b1;
        end
      end else begin
        // Release keeps note/velocity/rank for the envelope tail
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
          if (gate_q[i] && (note_q[i] == ev_q.note)) gate_d[i] = 1'b0;
        end
      end
    end
  end

  assign o_gate     = gate_q;
  assign o_note     = note_q;
  assign o_velocity = vel_q;
  assign o_update   = upd_q;
  assign o_dropped  = drop_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Scoreboard bench for voice_alloc: a behavioural parser/allocator model
// queues the expected voice snapshot per event, due two edges after the
// completing byte; every cycle the visible outputs are compared.
module tb_voice_alloc;

  localparam int unsigned NV = 4;

  logic                 i_clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_valid = 1'b0;
  logic [7:0]           i_data = 8'h00;
  logic [NV-1:0]        o_gate;
  logic [NV-1:0][6:0]   o_note;
  logic [NV-1:0][6:0]   o_velocity;
  logic [NV-1:0]        o_update;
  logic                 o_dropped;

  voice_alloc #(.NUM_VOICES(NV), .MIDI_CHANNEL(0)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_gate     (o_gate),
    .o_note     (o_note),
    .o_velocity (o_velocity),
    .o_update   (o_update),
    .o_dropped  (o_dropped)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int                due;
    logic [NV-1:0]     gate;
    logic [NV*7-1:0]   note;
    logic [NV*7-1:0]   vel;
    logic [NV-1:0]     upd;
    logic              drop;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [7:0]  bq[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // model state
  logic [NV-1:0] m_gate;
  logic [6:0]    m_note [NV];
  logic [6:0]    m_vel  [NV];
  int            m_rank [NV];
  int            m_st;      // 0 idle, 1 ignore, 2 wait d1, 3 wait d2
  logic          m_on;
  logic [6:0]    m_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_gate = '0;
    for (int i = 0; i < int'(NV); i++) begin
      m_note[i] = '0; m_vel[i] = '0; m_rank[i] = i;
    end
    m_st = 0; m_on = 1'b0; m_n = '0;
    q.delete();
    cur.gate = '0; cur.note = '0; cur.vel = '0; cur.upd = '0; cur.drop = 1'b0; cur.due = 0;
  endtask

  task automatic model_event(input logic on, input logic [6:0] n, input logic [6:0] v);
    exp_t e;
    int   sel;
    int   old;
    e.upd = '0; e.drop = 1'b0;
    if (on) begin
      sel = -1;
      for (int i = 0; i < int'(NV); i++) if (sel < 0 && m_gate[i] && m_note[i] == n) sel = i;
      for (int i = 0; i < int'(NV); i++) if (sel < 0 && !m_gate[i]) sel = i;
`ifdef VOICE_STEAL_EN
      for (int i = 0; i < int'(NV); i++) if (sel < 0 && m_rank[i] == int'(NV) - 1) sel = i;
`endif
      if (sel >= 0) begin
        old = m_rank[sel];
        for (int j = 0; j < int'(NV); j++) if (m_rank[j] < old) m_rank[j]++;
        m_rank[sel] = 0;
        m_gate[sel] = 1'b1; m_note[sel] = n; m_vel[sel] = v;
        e.upd[sel] = 1'b1;
      end else begin
        e.drop = 1'b1;
      end
    end else begin
      for (int i = 0; i < int'(NV); i++) if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
    end
    e.due  = cyc + 3;
    e.gate = m_gate;
    for (int i = 0; i < int'(NV); i++) begin
      e.note[i*7 +: 7] = m_note[i];
      e.vel[i*7 +: 7]  = m_vel[i];
    end
    q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'hF8) begin
    end else if (b >= 8'hF0) begin
      m_st = 0;
    end else if (b[7]) begin
      if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && b[3:0] == 4'h0) begin
        m_on = b[4]; m_st = 2;
      end else begin
        m_st = 1;
      end
    end else if (m_st == 2) begin
      m_n = b[6:0]; m_st = 3;
    end else if (m_st == 3) begin
      model_event(m_on && b[6:0] != 7'd0, m_n, b[6:0]);
      m_st = 2;
    end
  endtask

  task automatic monitor();
    if (q.size() > 0 && q[0].due == cyc) cur = q.pop_front();
    else begin
      cur.upd = '0; cur.drop = 1'b0;
    end
    check("gate",     32'(o_gate),     32'(cur.gate));
    check("note",     32'(o_note),     32'(cur.note));
    check("velocity", 32'(o_velocity), 32'(cur.vel));
    check("update",   32'(o_update),   32'(cur.upd));
    check("dropped",  32'(o_dropped),  32'(cur.drop));
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] b);
    i_reset = r; i_valid = v; i_data = b;
    if (r) model_reset();
    else if (v) model_byte(b);
    @(posedge i_clk);
    cyc++;
    #1;
    monitor();
  endtask

  task automatic flush();
    while (bq.size() > 0) step(1'b0, 1'b1, bq.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic fill4();
    bq = '{8'h90, 8'h30, 8'h7F, 8'h31, 8'h7F, 8'h32, 8'h7F, 8'h33, 8'h7F};
    flush();
    idle(3);
  endtask

  initial begin
    model_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("rst_gate", 32'(o_gate), 32'h0);
    idle(2);

    // single Note On, pulse exactly two edges after last strobe
    bq = '{8'h90, 8'h3C, 8'h64};
    flush();
    idle(1);
    check("t1_upd_early", 32'(o_update), 32'h0);
    idle(1);
    check("t1_upd", 32'(o_update), 32'h1);
    check("t1_note0", 32'(o_note[0]), 32'h3C);
    check("t1_vel0", 32'(o_velocity[0]), 32'h64);
    idle(1);
    check("t1_upd_off", 32'(o_update), 32'h0);
    idle(2);

    // running status and Note On velocity 0 as release
    do_reset();
    bq = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50, 8'h3C, 8'h00};
    flush();
    idle(4);
    check("t2_gate", 32'(o_gate), 32'h2);
    check("t2_note1", 32'(o_note[1]), 32'h40);
    check("t2_note0_kept", 32'(o_note[0]), 32'h3C);

    // channel filter, other status ignored, real-time inside message, unmatched off
    do_reset();
    bq = '{8'h91, 8'h3C, 8'h64, 8'hB0, 8'h07, 8'h7F, 8'h90, 8'h45, 8'hF8, 8'h70,
           8'h80, 8'h12, 8'h40};
    flush();
    idle(4);
    check("t3_gate", 32'(o_gate), 32'h1);
    check("t3_note0", 32'(o_note[0]), 32'h45);
    check("t3_vel0", 32'(o_velocity[0]), 32'h70);

    // overflow: steal oldest or drop
    do_reset();
    fill4();
    bq = '{8'h50, 8'h7F};
    flush();
    idle(2);
`ifdef VOICE_STEAL_EN
    check("t4_upd", 32'(o_update), 32'h1);
    check("t4_note0", 32'(o_note[0]), 32'h50);
`else
    check("t4_drop", 32'(o_dropped), 32'h1);
    check("t4_note0", 32'(o_note[0]), 32'h30);
`endif
    idle(2);

    // retrigger updates rank; subsequent overflows pick voice0 then voice2
    do_reset();
    fill4();
    bq = '{8'h31, 8'h40};
    flush();
    idle(2);
    check("t5_retrig", 32'(o_update), 32'h2);
    check("t5_vel1", 32'(o_velocity[1]), 32'h40);
    bq = '{8'h50, 8'h7F, 8'h51, 8'h7F};
    flush();
    idle(4);
`ifdef VOICE_STEAL_EN
    check("t5_note0", 32'(o_note[0]), 32'h50);
    check("t5_note2", 32'(o_note[2]), 32'h51);
`else
    check("t5_note0", 32'(o_note[0]), 32'h30);
    check("t5_note2", 32'(o_note[2]), 32'h32);
`endif

    // reset mid-message discards the partial message
    do_reset();
    bq = '{8'h90, 8'h3C};
    flush();
    do_reset();
    bq = '{8'h64};
    flush();
    idle(4);
    check("t6_gate", 32'(o_gate), 32'h0);
    check("t6_note", 32'(o_note), 32'h0);

    // randomized traffic with running status and real-time bytes
    do_reset();
    bq = '{8'h90};
    for (int k = 0; k < 80; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) bq.push_back(8'h80);
      else if (r < 4) bq.push_back(8'h90);
      bq.push_back(8'(8'h40 + $urandom_range(0, 5)));
      if ($urandom_range(0, 7) == 0) bq.push_back(8'hF8);
      if ($urandom_range(0, 3) == 0) bq.push_back(8'h00);
      else bq.push_back(8'($urandom_range(1, 127)));
      flush();
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(5);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
